sel_arb: RTL and testbench
==========================

SEL_ARB -- requirements
Module: sel_arb

Interface
REQ-001 Parameter NCH, 4, number of input channels (>=2).
REQ-002 Parameter DW, 32, data width per channel in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  NCH  per-channel request; bit i belongs to channel i.
REQ-006 in_data  input  NCH*DW  packed channel data; channel i at bits [i*DW +: DW].
REQ-007 in_ready  output  NCH  per-channel accept; beat i transfers when in_valid[i] && in_ready[i].
REQ-008 out_valid  output  1  registered output beat present.
REQ-009 out_data  output  DW  registered selected data.
REQ-010 out_grant  output  NCH  one-hot tag of the channel that supplied out_data.
REQ-011 out_ready  input  1  downstream accept; beat leaves when out_valid && out_ready.

Function
REQ-012 The block SHALL arbitrate round-robin among asserted in_valid bits; the highest priority goes to the channel after the last granted one, wrapping from NCH-1 to 0.
REQ-013 The grant vector SHALL be one-hot or all-zero, never more than one bit set.
REQ-014 Load enable SHALL be ld = (!out_valid || out_ready) && |in_valid.
REQ-015 in_ready SHALL equal grant gated by (!out_valid || out_ready); combinational from in_valid, out_valid, out_ready and pointer; at most one bit set.
REQ-016 When ld, the next edge SHALL capture the AND-OR one-hot selection of in_data into out_data, grant into out_grant, set out_valid=1, and move the pointer to the granted channel.
REQ-017 When out_valid && out_ready && !|in_valid, the next edge SHALL clear out_valid; out_data and out_grant SHALL hold their values.
REQ-018 When out_valid && !out_ready, out_valid, out_data, out_grant and the pointer SHALL hold; in_ready SHALL be all-zero.
REQ-019 Pop and load in the same cycle SHALL replace the beat with no bubble; sustained throughput is one beat per cycle.
REQ-020 Latency from in_valid&&in_ready to out_valid SHALL be exactly one cycle.
REQ-021 A single requesting channel SHALL be granted every cycle the output can accept, regardless of pointer position.
REQ-022 With all NCH channels requesting continuously and out_ready=1, each channel SHALL be granted exactly once in every NCH consecutive grants.
REQ-023 The pointer SHALL advance only on a transfer, never on stall or idle.

Reset
REQ-024 While rst=1 at an edge: out_valid=0, out_data=0, out_grant=0, and the pointer set so channel 0 has highest priority.
REQ-025 Reset mid-operation SHALL discard a held beat; in_ready SHALL be all-zero in the cycle rst is asserted.

Structure
REQ-026 The AND-OR one-hot data selection SHALL be a sub-module sel_onehot (parameters NCH, DW; inputs sel[NCH], data[NCH*DW]; output out[DW]), purely combinational.
REQ-027 Round-robin priority logic (rotate, find-first, rotate back) SHALL live in sel_arb; no shared package is required, as parameters are module-local.

Verification (NCH=4, DW=8)
REQ-028 Reset, then in_valid=4'b0001, in_data[7:0]=8'h11, out_ready=1 -> in_ready=4'b0001; next cycle out_valid=1, out_data=8'h11, out_grant=4'b0001.
REQ-029 in_valid=4'b1111 held, data ch i = 8'hA0+i, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles.
REQ-030 Beat from ch2 (8'h22) held with out_ready=0 for 3 cycles while ch1 and ch3 request -> out_data stays 8'h22, in_ready=0, pointer unchanged; on out_ready=1 the next beat is ch3.
REQ-031 out_valid=1, out_ready=1, in_valid=0 -> out_valid=0 next cycle, out_data unchanged.
REQ-032 rst asserted while out_valid=1 and out_ready=0 -> out_valid=0, out_grant=0 next cycle; with all channels requesting after reset, the first grant is ch0.
REQ-033 Random in_valid/out_ready for 10k cycles -> grant always one-hot or zero, no beat lost or duplicated (scoreboard per channel), and no requesting channel waits more than NCH transfers.

Source files
------------

// File: rtl/sel_arb_pkg.sv
// Shared defaults for the selecting round-robin arbiter slice.
package sel_arb_pkg;

    // Default channel count and per-channel data width.
    localparam int DEF_NCH = 4;
    localparam int DEF_DW  = 32;

endpackage

// File: rtl/sel_onehot.sv
// AND-OR one-hot multiplexer: ORs together every channel whose select bit is set.
module sel_onehot #(
    parameter int NCH = 4,
    parameter int DW  = 32
) (
    input  logic [NCH-1:0]    sel,
    input  logic [NCH*DW-1:0] data,
    output logic [DW-1:0]     out
);

    // Mask each channel by its select bit and merge; a one-hot select yields that channel.
    always_comb begin
        out = '0;
        for (int i = 0; i < NCH; i++) begin
            out = out | (data[i*DW +: DW] & {DW{sel[i]}});
        end
    end

endmodule

// File: rtl/sel_arb.sv
// Round-robin arbiter feeding a single registered output beat with one-cycle latency.
module sel_arb
    import sel_arb_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int DW  = DEF_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [NCH-1:0]    out_grant,
    input  logic              out_ready
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    // ptr holds the index of the last granted channel; the next one up has top priority.
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    start;
    logic [NCH-1:0]   req_rot;
    logic [NCH-1:0]   gnt_rot;
    logic [PW-1:0]    rot_idx;
    logic [2*NCH-1:0] gnt_dbl;
    logic [NCH-1:0]   grant;
    logic [PW-1:0]    gnt_idx;
    logic [PW:0]      idx_sum;
    logic             found;
    logic             can_load;
    logic             ld;
    logic [DW-1:0]    sel_data;

    // Rotate requests so the top-priority channel lands at bit 0.
    always_comb begin
        start   = (ptr == PW'(NCH - 1)) ? '0 : ptr + 1'b1;
        req_rot = NCH'({in_valid, in_valid} >> start);
    end

    // Find the first requester in rotated order.
    always_comb begin
        gnt_rot = '0;
        rot_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && req_rot[i]) begin
                gnt_rot[i] = 1'b1;
                rot_idx    = PW'(i);
                found      = 1'b1;
            end
        end
    end

    // Rotate the grant back to channel positions and recover its absolute index.
    always_comb begin
        gnt_dbl = {gnt_rot, gnt_rot} << start;
        grant   = gnt_dbl[2*NCH-1:NCH];
        idx_sum = {1'b0, rot_idx} + {1'b0, start};
        if (idx_sum >= (PW+1)'(NCH)) begin
            idx_sum = idx_sum - (PW+1)'(NCH);
        end
        gnt_idx = idx_sum[PW-1:0];
    end

    // Output slot accepts a new beat when empty or being drained; nothing is accepted in reset.
    always_comb begin
        can_load = (!out_valid || out_ready) && !rst;
        ld       = can_load && (|in_valid);
        in_ready = can_load ? grant : '0;
    end

    sel_onehot #(
        .NCH (NCH),
        .DW  (DW)
    ) u_sel (
        .sel  (grant),
        .data (in_data),
        .out  (sel_data)
    );

    // Output register and priority pointer; pointer moves only when a beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            ptr       <= PW'(NCH - 1);
        end else if (ld) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_grant <= grant;
            ptr       <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sel_arb.sv
// Directed and randomized checks for sel_arb with four 8-bit channels.
module tb_sel_arb;

    localparam int NCH = 4;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [NCH-1:0]    out_grant;
    logic              out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    sel_arb #(.NCH(NCH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_grant (out_grant),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 4'b1111;
        in_data = 32'h44332211;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
        end
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_out_data got=%h exp=00", out_data);
        end
        n_checks++;
        if (out_grant !== 4'b0000) begin
            n_fail++; $display("FAIL reset_out_grant got=%b exp=0000", out_grant);
        end
        rst = 1'b0;
        in_valid = '0;
    endtask

    task automatic test_single();
        in_valid = 4'b0001;
        in_data = 32'h00000011;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_in_ready got=%b exp=0001", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || out_grant !== 4'b0001) begin
            n_fail++; $display("FAIL single_out got v=%b d=%h g=%b exp v=1 d=11 g=0001",
                               out_valid, out_data, out_grant);
        end
        // lone requester on ch2 granted every cycle
        in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            in_data = {8'h00, 8'h30 + 8'(k), 16'h0000};
            #1;
            n_checks++;
            if (in_ready !== 4'b0100) begin
                n_fail++; $display("FAIL lone_in_ready[%0d] got=%b exp=0100", k, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h30 + 8'(k) || out_grant !== 4'b0100) begin
                n_fail++; $display("FAIL lone_out[%0d] got v=%b d=%h g=%b exp v=1 d=%h g=0100",
                                   k, out_valid, out_data, out_grant, 8'h30 + 8'(k));
            end
        end
    endtask

    task automatic test_drain();
        // out_valid=1 holding 8'h32 from the previous task
        in_valid = 4'b0000;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL drain_in_ready got=%b exp=0000", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h32 || out_grant !== 4'b0100) begin
            n_fail++; $display("FAIL drain_out got v=%b d=%h g=%b exp v=0 d=32 g=0100",
                               out_valid, out_data, out_grant);
        end
    endtask

    task automatic test_rr_all();
        logic [7:0] exp_d;
        logic [3:0] exp_g;
        do_reset();
        in_valid = 4'b1111;
        in_data = 32'hA3A2A1A0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_d = 8'hA0 + 8'(k % 4);
            exp_g = 4'(1 << (k % 4));
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_grant !== exp_g) begin
                n_fail++; $display("FAIL rr_all[%0d] got v=%b d=%h g=%b exp v=1 d=%h g=%b",
                                   k, out_valid, out_data, out_grant, exp_d, exp_g);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        in_valid = 4'b0100;
        in_data = 32'h23222120;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_data !== 8'h22 || out_grant !== 4'b0100) begin
            n_fail++; $display("FAIL stall_load got d=%h g=%b exp d=22 g=0100", out_data, out_grant);
        end
        out_ready = 1'b0;
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++; $display("FAIL stall_in_ready[%0d] got=%b exp=0000", k, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h22 || out_grant !== 4'b0100) begin
                n_fail++; $display("FAIL stall_hold[%0d] got v=%b d=%h g=%b exp v=1 d=22 g=0100",
                                   k, out_valid, out_data, out_grant);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin
            n_fail++; $display("FAIL stall_release_ready got=%b exp=1000", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h23 || out_grant !== 4'b1000) begin
            n_fail++; $display("FAIL stall_release got v=%b d=%h g=%b exp v=1 d=23 g=1000",
                               out_valid, out_data, out_grant);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 4'b0010;
        in_data = 32'h44332211;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 4'b1111;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_in_ready got=%b exp=0000", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_grant !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_out got v=%b g=%b exp v=0 g=0000", out_valid, out_grant);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rstmid_first_ready got=%b exp=0001", in_ready);
        end
        tick();
        n_checks++;
        if (out_grant !== 4'b0001 || out_data !== 8'h11) begin
            n_fail++; $display("FAIL rstmid_first_grant got g=%b d=%h exp g=0001 d=11", out_grant, out_data);
        end
    endtask

    task automatic test_random();
        logic       m_valid;
        logic [7:0] m_data;
        logic [3:0] m_grant;
        int         mptr;
        int         midx;
        logic [3:0] mg;
        logic [5:0] seq [NCH];
        int         wait_cnt [NCH];
        do_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_grant = 4'b0000;
        mptr    = NCH - 1;
        for (int c = 0; c < NCH; c++) begin
            seq[c] = '0;
            wait_cnt[c] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < NCH; c++) in_data[c*DW +: DW] = {2'(c), seq[c]};
            #1;
            midx = -1;
            if (!m_valid || out_ready) begin
                for (int k = 1; k <= NCH; k++) begin
                    if (midx < 0 && in_valid[(mptr + k) % NCH]) midx = (mptr + k) % NCH;
                end
            end
            mg = (midx >= 0) ? 4'(1 << midx) : 4'b0000;
            n_checks++;
            if (in_ready !== mg) begin
                n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, mg);
            end
            n_checks++;
            if (!$onehot0(in_ready)) begin
                n_fail++; $display("FAIL rand_onehot cyc=%0d got=%b exp=onehot0", cyc, in_ready);
            end
            tick();
            if (midx >= 0) begin
                m_valid = 1'b1;
                m_data  = {2'(midx), seq[midx]};
                m_grant = mg;
                mptr    = midx;
                for (int c = 0; c < NCH; c++) begin
                    if (c == midx || !in_valid[c]) begin
                        wait_cnt[c] = 0;
                    end else begin
                        wait_cnt[c]++;
                        n_checks++;
                        if (wait_cnt[c] >= NCH) begin
                            n_fail++; $display("FAIL rand_starve cyc=%0d ch=%0d got=%0d exp<%0d",
                                               cyc, c, wait_cnt[c], NCH);
                        end
                    end
                end
                seq[midx] = seq[midx] + 6'd1;
            end else begin
                if (out_ready) m_valid = 1'b0;
                for (int c = 0; c < NCH; c++) if (!in_valid[c]) wait_cnt[c] = 0;
            end
            n_checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_grant !== m_grant) begin
                n_fail++; $display("FAIL rand_out cyc=%0d got v=%b d=%h g=%b exp v=%b d=%h g=%b",
                                   cyc, out_valid, out_data, out_grant, m_valid, m_data, m_grant);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_drain();
        test_rr_all();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
